// File: rtl/sample_packer.sv
`timescale 1ns / 1ps
// Serial-to-parallel packer: SAMPLE_W-bit samples -> {flag, pad, N slots} words with valid/ready
// on both sides. Define PACKER_DROP_EN for a non-stallable upstream with a saturating drop_cnt port.
module sample_packer #(
  parameter int SAMPLE_W        = 10,
  parameter int OUT_W           = 256,
  parameter int FLAG_W          = 6,
  parameter int FRAMES_PER_FLAG = 50000
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_last
`ifdef PACKER_DROP_EN
  ,
  output logic [15:0]         drop_cnt
`endif
);

  localparam int N      = (OUT_W - FLAG_W) / SAMPLE_W;
  localparam int DATA_W = N * SAMPLE_W;
  localparam int SLOT_W = (N > 1) ? $clog2(N) : 1;
  localparam int FC_W   = (FRAMES_PER_FLAG > 1) ? $clog2(FRAMES_PER_FLAG) : 1;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N - 1);
  localparam logic [FC_W-1:0]   FC_MAX    = FC_W'(FRAMES_PER_FLAG - 1);
  localparam logic [FLAG_W-1:0] FLAG_MAX  = '1;

  logic [DATA_W-1:0] pack_data;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] src_data;
  logic [SLOT_W-1:0] slot;
  logic              pack_full;
  logic              pack_last;
  logic [FC_W-1:0]   frame_cnt;
  logic [FLAG_W-1:0] flag_cnt;
  logic [OUT_W-1:0]  load_word;
  logic              accept;
  logic              complete;
  logic              out_free;
  logic              load_en;
  logic              src_last;
  logic              dropped;

  // The pack register doubles as the accumulator and the one-word skid buffer.
  assign in_ready = ~pack_full;
  assign accept   = in_valid & ~pack_full;
  assign complete = accept & ((slot == LAST_SLOT) | in_last);
  assign out_free = ~out_valid | out_ready;

`ifdef PACKER_DROP_EN
  assign dropped = in_valid & pack_full;
`else
  assign dropped = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    merged = pack_data;
    for (int k = 0; k < N; k++) begin
      if (slot == SLOT_W'(k)) merged[k*SAMPLE_W +: SAMPLE_W] = in_data;
    end
  end

  always_comb begin
    src_data  = merged;
    src_last  = in_last;
    load_en   = complete & out_free;
    if (pack_full) begin
      src_data = pack_data;
      // A last-flagged sample dropped while a word is held still closes that frame.
      src_last = pack_last | (dropped & in_last);
      load_en  = out_free;
    end
    load_word                 = '0;
    load_word[DATA_W-1:0]     = src_data;
    if (src_last) load_word[OUT_W-1 -: FLAG_W] = flag_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      pack_data <= '0;
      pack_full <= 1'b0;
      pack_last <= 1'b0;
      slot      <= '0;
      frame_cnt <= '0;
      flag_cnt  <= FLAG_W'(1);
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (load_en) begin
        out_valid <= 1'b1;
        out_data  <= load_word;
        out_last  <= src_last;
        if (src_last) begin
          if (frame_cnt == FC_MAX) begin
            frame_cnt <= '0;
            flag_cnt  <= (flag_cnt == FLAG_MAX) ? FLAG_W'(1) : flag_cnt + 1'b1;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end

      if (pack_full) begin
        if (out_free) begin
          pack_full <= 1'b0;
          pack_data <= '0;
          pack_last <= 1'b0;
        end else if (dropped && in_last) begin
          pack_last <= 1'b1;
        end
      end else if (accept) begin
        if (complete) begin
          slot <= '0;
          if (out_free) begin
            pack_data <= '0;
          end else begin
            pack_data <= merged;
            pack_last <= in_last;
            pack_full <= 1'b1;
          end
        end else begin
          pack_data <= merged;
          slot      <= slot + 1'b1;
        end
      end
    end
  end

`ifdef PACKER_DROP_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      drop_cnt <= '0;
    end else if (dropped && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_packer.sv
`timescale 1ns / 1ps
// Directed bench for sample_packer: a per-cycle handshake table plus hand-written multi-cycle
// sequences (streaming, backpressure, flag rollover, reset mid-word, optional drop counting).
module tb_sample_packer;

  localparam int SW = 10;
  localparam int OW = 256;

  logic          clk       = 1'b0;
  logic          nrst      = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_last   = 1'b0;
  logic          out_ready = 1'b0;
  logic [SW-1:0] in_data   = '0;

  logic          in_ready_a, out_valid_a, out_last_a;
  logic          in_ready_b, out_valid_b, out_last_b;
  logic [OW-1:0] out_data_a, out_data_b;
`ifdef PACKER_DROP_EN
  logic [15:0]   drop_cnt_a, drop_cnt_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
  } word_t;

  word_t q_a[$];
  word_t q_b[$];

  always #5 clk = ~clk;

  sample_packer dut_a (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_last(out_last_a)
`ifdef PACKER_DROP_EN
    , .drop_cnt(drop_cnt_a)
`endif
  );

  sample_packer #(.FRAMES_PER_FLAG(3), .FLAG_W(2)) dut_b (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_last(out_last_b)
`ifdef PACKER_DROP_EN
    , .drop_cnt(drop_cnt_b)
`endif
  );

  // Inputs change just after posedge, so negedge sees a stable handshake.
  always @(negedge clk) begin
    if (nrst) begin
      if (out_valid_a && out_ready) q_a.push_back('{out_data_a, out_last_a});
      if (out_valid_b && out_ready) q_b.push_back('{out_data_b, out_last_b});
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] make_word(input int start, input int cnt, input int flag,
                                               input int flag_w);
    logic [OW-1:0] w;
    w = '0;
    for (int k = 0; k < cnt; k++) w[k*SW +: SW] = SW'(start + k);
    w = w | (OW'(flag) << (OW - flag_w));
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    nrst      = 1'b0;
    #1;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_data", out_data_a, 0);
    check("rst_out_last", out_last_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    q_a.delete();
    q_b.delete();
  endtask

  // Present one sample and hold it until accepted; cycles reports how many edges it took.
  task automatic send(input logic [SW-1:0] d, input logic l, output int cycles);
    logic acc;
    cycles   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    do begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
      cycles++;
    end while (!acc && cycles < 1000);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_word(input string name, input word_t w, input logic [OW-1:0] exp_data,
                            input logic exp_last);
    check({name, "_data"}, w.data, exp_data);
    check({name, "_last"}, w.last, exp_last);
  endtask

  typedef struct {
    logic          v;
    logic [SW-1:0] d;
    logic          l;
    logic          ordy;
    logic          e_rdy;
    logic          e_ov;
    logic          e_ol;
    logic [19:0]   e_lo;
    logic [5:0]    e_flag;
  } vec_t;

  vec_t vec[8];

  initial begin
    int c;
    int total;
    int exp_flag[12];

    // One-sample frames exercise load, hold, stall and release in a handful of cycles.
    vec[0] = '{1'b1, 10'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 20'd5, 6'd1};
    vec[1] = '{1'b1, 10'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 20'd5, 6'd1};
    vec[2] = '{1'b1, 10'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'd5, 6'd1};
    vec[3] = '{1'b1, 10'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 20'd6, 6'd1};
    vec[4] = '{1'b1, 10'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'd0, 6'd0};
    vec[5] = '{1'b1, 10'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, (20'd8 << 10) | 20'd7, 6'd1};
    vec[6] = '{1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'd0, 6'd0};
    vec[7] = '{1'b1, 10'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'd0, 6'd0};

    exp_flag = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 1, 1, 1};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid  = vec[i].v;
      in_data   = vec[i].d;
      in_last   = vec[i].l;
      out_ready = vec[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("row%0d_in_ready", i), in_ready_a, vec[i].e_rdy);
      check($sformatf("row%0d_out_valid", i), out_valid_a, vec[i].e_ov);
      if (vec[i].e_ov) begin
        check($sformatf("row%0d_out_last", i), out_last_a, vec[i].e_ol);
        check($sformatf("row%0d_lo", i), out_data_a[19:0], vec[i].e_lo);
        check($sformatf("row%0d_flag", i), out_data_a[OW-1 -: 6], vec[i].e_flag);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    // Full-rate streaming: 50 samples, two full words, no stalls.
    do_reset();
    out_ready = 1'b1;
    total     = 0;
    for (int i = 0; i < 50; i++) begin
      send(SW'(i), 1'b0, c);
      total += c;
    end
    check("stream_cycles", total, 50);
    idle(3);
    check("stream_count", q_a.size(), 2);
    if (q_a.size() > 1) begin
      check_word("stream_w0", q_a[0], make_word(0, 25, 0, 6), 1'b0);
      check_word("stream_w1", q_a[1], make_word(25, 25, 0, 6), 1'b0);
    end

    // Short frame: 7 samples then zero padding, flag 1, out_last.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(SW'(100 + i), i == 6, c);
    idle(3);
    check("short_count", q_a.size(), 1);
    if (q_a.size() > 0) check_word("short_w0", q_a[0], make_word(100, 7, 1, 6), 1'b1);

    // Backpressure: out reg and pack reg both fill, then drain in order.
    do_reset();
    for (int i = 0; i < 50; i++) send(SW'(i), 1'b0, c);
    check("bp_in_ready_low", in_ready_a, 0);
    check("bp_out_valid", out_valid_a, 1);
    fork
      begin
        for (int i = 50; i < 75; i++) send(SW'(i), 1'b0, c);
      end
      begin
        for (int j = 0; j < 5; j++) begin
          @(posedge clk);
          #1;
          check($sformatf("bp_hold%0d_data", j), out_data_a, make_word(0, 25, 0, 6));
          check($sformatf("bp_hold%0d_ready", j), in_ready_a, 0);
        end
        out_ready = 1'b1;
      end
    join
    idle(5);
    check("bp_count", q_a.size(), 3);
    if (q_a.size() > 2) begin
      check_word("bp_w0", q_a[0], make_word(0, 25, 0, 6), 1'b0);
      check_word("bp_w1", q_a[1], make_word(25, 25, 0, 6), 1'b0);
      check_word("bp_w2", q_a[2], make_word(50, 25, 0, 6), 1'b0);
    end

    // Flag rollover on the FRAMES_PER_FLAG=3, FLAG_W=2 instance: 12 one-sample frames.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(SW'(200 + i), 1'b1, c);
    idle(3);
    check("flag_count_b", q_b.size(), 12);
    check("flag_count_a", q_a.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (q_b.size() > i)
        check_word($sformatf("flag_b%0d", i), q_b[i], make_word(200 + i, 1, exp_flag[i], 2), 1'b1);
    end
    if (q_a.size() > 11) check_word("flag_a11", q_a[11], make_word(211, 1, 1, 6), 1'b1);

    // Reset while a word is stalled and another is half packed.
    do_reset();
    for (int i = 0; i < 35; i++) send(SW'(i), 1'b0, c);
    check("mid_out_valid_pre", out_valid_a, 1);
    nrst = 1'b0;
    #1;
    check("mid_out_valid", out_valid_a, 0);
    check("mid_out_data", out_data_a, 0);
    check("mid_in_ready", in_ready_a, 1);
    idle(1);
    nrst = 1'b1;
    q_a.delete();
    out_ready = 1'b1;
    idle(5);
    check("mid_no_output", q_a.size(), 0);
    for (int i = 0; i < 25; i++) send(SW'(400 + i), i == 24, c);
    idle(3);
    check("mid_count", q_a.size(), 1);
    if (q_a.size() > 0) check_word("mid_w0", q_a[0], make_word(400, 25, 1, 6), 1'b1);

`ifdef PACKER_DROP_EN
    // Non-stallable upstream: 60 samples against a blocked sink drop the last 10.
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      in_data = SW'(i);
      @(posedge clk);
      #1;
    end
    check("drop_cnt_10", drop_cnt_a, 16'd10);
    repeat (70000) begin
      @(posedge clk);
      #1;
    end
    check("drop_cnt_sat", drop_cnt_a, 16'hFFFF);
    in_last = 1'b1;
    idle(1);
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(5);
    check("drop_count", q_a.size(), 2);
    if (q_a.size() > 1) begin
      check_word("drop_w0", q_a[0], make_word(0, 25, 0, 6), 1'b0);
      check_word("drop_w1", q_a[1], make_word(25, 25, 1, 6), 1'b1);
    end
    check("drop_cnt_hold", drop_cnt_a, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
